mem_stage_lsu: RTL and testbench



---
 rtl/mem_stage_lsu_if.sv | 47 ++++
 rtl/mem_stage_lsu.sv | 182 ++++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_lsu_if.sv
// Bundle of the EX/MEM inputs, data-memory bus and MEM/WB result signals of the memory stage.
// master is the LSU side; slave is the pipeline/memory environment that drives it.
`ifndef BUS_NONE
`define BUS_NONE  2'h0
`define BUS_LOAD  2'h1
`define BUS_STORE 2'h2
`endif

interface mem_stage_lsu_if #(
    parameter int XLEN = 32
);
    logic              ex_mem_valid_inst;
    logic              ex_mem_rd_mem;
    logic              ex_mem_wr_mem;
    logic [1:0]        ex_mem_mem_size;
    logic              ex_mem_mem_unsigned;
    logic [XLEN-1:0]   ex_mem_alu_result;
    logic [XLEN-1:0]   ex_mem_regb;
    logic              Dmem2proc_ready;
    logic              Dmem2proc_valid;
    logic [XLEN-1:0]   Dmem2proc_data;
    logic [1:0]        proc2Dmem_command;
    logic [XLEN-1:0]   proc2Dmem_addr;
    logic [XLEN-1:0]   proc2Dmem_data;
    logic [XLEN/8-1:0] proc2Dmem_be;
    logic              mem_stall;
    logic [XLEN-1:0]   mem_result_out;
    logic              mem_result_valid;
    logic              mem_misaligned;
    logic              mem_timeout;

    modport master (
        input  ex_mem_valid_inst, ex_mem_rd_mem, ex_mem_wr_mem, ex_mem_mem_size,
               ex_mem_mem_unsigned, ex_mem_alu_result, ex_mem_regb,
               Dmem2proc_ready, Dmem2proc_valid, Dmem2proc_data,
        output proc2Dmem_command, proc2Dmem_addr, proc2Dmem_data, proc2Dmem_be,
               mem_stall, mem_result_out, mem_result_valid, mem_misaligned, mem_timeout
    );

    modport slave (
        output ex_mem_valid_inst, ex_mem_rd_mem, ex_mem_wr_mem, ex_mem_mem_size,
               ex_mem_mem_unsigned, ex_mem_alu_result, ex_mem_regb,
               Dmem2proc_ready, Dmem2proc_valid, Dmem2proc_data,
        input  proc2Dmem_command, proc2Dmem_addr, proc2Dmem_data, proc2Dmem_be,
               mem_stall, mem_result_out, mem_result_valid, mem_misaligned, mem_timeout
    );
endinterface

// File: rtl/mem_stage_lsu.sv
// Variable-latency memory stage: issues sized loads/stores, formats load data,
// stalls while a load is outstanding, and flags misaligned accesses and timeouts.
//
// state  | meaning
// S_IDLE | no load outstanding; commands driven combinationally from EX/MEM
// S_WAIT | load accepted by memory, waiting for Dmem2proc_valid or timeout
`ifndef BUS_NONE
`define BUS_NONE  2'h0
`define BUS_LOAD  2'h1
`define BUS_STORE 2'h2
`endif

module mem_stage_lsu #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 64
) (
    input logic             clk,
    input logic             rst,
    mem_stage_lsu_if.master bus
);
    localparam int NB  = XLEN / 8;
    localparam int OFF = $clog2(NB);
    localparam int CW  = ($clog2(TIMEOUT) > 5) ? $clog2(TIMEOUT) : 5;

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;

    logic [OFF-1:0]  off;
    logic            mem_op;
    logic            aligned;
    logic [XLEN-1:0] st_data;
    logic [NB-1:0]   be_base;
    logic [XLEN-1:0] ld_shift;
    logic [XLEN-1:0] ld_fmt;

    logic [1:0]      cmd;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
    logic [NB-1:0]   be;
    logic            stall;
    logic [XLEN-1:0] result;
    logic            result_valid;
    logic            misaligned;
    logic            timeout;

    assign off      = bus.ex_mem_alu_result[OFF-1:0];
    assign mem_op   = bus.ex_mem_valid_inst & (bus.ex_mem_rd_mem | bus.ex_mem_wr_mem);
    assign ld_shift = bus.Dmem2proc_data >> {off, 3'b000};

    // Size 11 is only legal on a 64-bit datapath.
    always_comb begin
        aligned = 1'b0;
        case (bus.ex_mem_mem_size)
            2'b00: aligned = 1'b1;
            2'b01: aligned = ~bus.ex_mem_alu_result[0];
            2'b10: aligned = (bus.ex_mem_alu_result[1:0] == 2'b00);
            2'b11: aligned = (XLEN == 64) && (bus.ex_mem_alu_result[2:0] == 3'b000);
            default: aligned = 1'b0;
        endcase
    end

    always_comb begin
        st_data = bus.ex_mem_regb;
        be_base = '1;
        case (bus.ex_mem_mem_size)
            2'b00: begin
                st_data = {NB{bus.ex_mem_regb[7:0]}};
                be_base = NB'(1);
            end
            2'b01: begin
                st_data = {(NB/2){bus.ex_mem_regb[15:0]}};
                be_base = NB'(3);
            end
            2'b10: begin
                st_data = {(NB/4){bus.ex_mem_regb[31:0]}};
                be_base = NB'(15);
            end
            default: begin
                st_data = bus.ex_mem_regb;
                be_base = '1;
            end
        endcase
    end

    always_comb begin
        ld_fmt = ld_shift;
        case (bus.ex_mem_mem_size)
            2'b00: ld_fmt = bus.ex_mem_mem_unsigned ? XLEN'(ld_shift[7:0])
                                                    : XLEN'($signed(ld_shift[7:0]));
            2'b01: ld_fmt = bus.ex_mem_mem_unsigned ? XLEN'(ld_shift[15:0])
                                                    : XLEN'($signed(ld_shift[15:0]));
            2'b10: ld_fmt = bus.ex_mem_mem_unsigned ? XLEN'(ld_shift[31:0])
                                                    : XLEN'($signed(ld_shift[31:0]));
            default: ld_fmt = ld_shift;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Outputs stay at their defaults while rst is high, regardless of state.
    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        cmd          = `BUS_NONE;
        addr         = '0;
        data         = '0;
        be           = '0;
        stall        = 1'b0;
        result       = '0;
        result_valid = 1'b0;
        misaligned   = 1'b0;
        timeout      = 1'b0;
        if (!rst) begin
            case (state)
                S_IDLE: begin
                    if (mem_op) begin
                        if (!aligned) begin
                            misaligned   = 1'b1;
                            result_valid = 1'b1;
                        end else begin
                            cmd  = bus.ex_mem_rd_mem ? `BUS_LOAD : `BUS_STORE;
                            addr = {bus.ex_mem_alu_result[XLEN-1:OFF], {OFF{1'b0}}};
                            data = bus.ex_mem_wr_mem ? st_data : '0;
                            be   = be_base << off;
                            if (!bus.Dmem2proc_ready) begin
                                stall = 1'b1;
                            end else if (bus.ex_mem_wr_mem) begin
                                result       = bus.ex_mem_alu_result;
                                result_valid = 1'b1;
                            end else begin
                                stall   = 1'b1;
                                state_n = S_WAIT;
                                cnt_n   = '0;
                            end
                        end
                    end else if (bus.ex_mem_valid_inst) begin
                        result       = bus.ex_mem_alu_result;
                        result_valid = 1'b1;
                    end
                end
                S_WAIT: begin
                    if (bus.Dmem2proc_valid) begin
                        result       = ld_fmt;
                        result_valid = 1'b1;
                        state_n      = S_IDLE;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        timeout      = 1'b1;
                        result_valid = 1'b1;
                        state_n      = S_IDLE;
                    end else begin
                        cnt_n = cnt + 1'b1;
                        stall = 1'b1;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    assign bus.proc2Dmem_command = cmd;
    assign bus.proc2Dmem_addr    = addr;
    assign bus.proc2Dmem_data    = data;
    assign bus.proc2Dmem_be      = be;
    assign bus.mem_stall         = stall;
    assign bus.mem_result_out    = result;
    assign bus.mem_result_valid  = result_valid;
    assign bus.mem_misaligned    = misaligned;
    assign bus.mem_timeout       = timeout;
endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: a 32-bit (TIMEOUT=4) and a 64-bit (TIMEOUT=6) instance,
// directed cases plus random transactions checked against a transaction-level model.
module tb_mem_stage_lsu;
    localparam logic [1:0] C_NONE  = 2'h0;
    localparam logic [1:0] C_LOAD  = 2'h1;
    localparam logic [1:0] C_STORE = 2'h2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_stage_lsu_if #(.XLEN(32)) bus32 ();
    mem_stage_lsu_if #(.XLEN(64)) bus64 ();

    mem_stage_lsu #(.XLEN(32), .TIMEOUT(4)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
    mem_stage_lsu #(.XLEN(64), .TIMEOUT(6)) dut64 (.clk(clk), .rst(rst), .bus(bus64));

    int          sel;
    logic        valid, rd, wr, uns, ready, dvalid;
    logic [1:0]  size;
    logic [63:0] alu, regb, ddata;

    always_comb begin
        bus32.ex_mem_valid_inst   = valid && (sel == 0);
        bus32.ex_mem_rd_mem       = rd;
        bus32.ex_mem_wr_mem       = wr;
        bus32.ex_mem_mem_size     = size;
        bus32.ex_mem_mem_unsigned = uns;
        bus32.ex_mem_alu_result   = alu[31:0];
        bus32.ex_mem_regb         = regb[31:0];
        bus32.Dmem2proc_ready     = ready && (sel == 0);
        bus32.Dmem2proc_valid     = dvalid && (sel == 0);
        bus32.Dmem2proc_data      = ddata[31:0];
        bus64.ex_mem_valid_inst   = valid && (sel == 1);
        bus64.ex_mem_rd_mem       = rd;
        bus64.ex_mem_wr_mem       = wr;
        bus64.ex_mem_mem_size     = size;
        bus64.ex_mem_mem_unsigned = uns;
        bus64.ex_mem_alu_result   = alu;
        bus64.ex_mem_regb         = regb;
        bus64.Dmem2proc_ready     = ready && (sel == 1);
        bus64.Dmem2proc_valid     = dvalid && (sel == 1);
        bus64.Dmem2proc_data      = ddata;
    end

    logic [1:0]  o_cmd;
    logic [63:0] o_addr, o_data, o_res;
    logic [7:0]  o_be;
    logic        o_stall, o_rv, o_mis, o_to;

    always_comb begin
        if (sel == 0) begin
            o_cmd   = bus32.proc2Dmem_command;
            o_addr  = {32'b0, bus32.proc2Dmem_addr};
            o_data  = {32'b0, bus32.proc2Dmem_data};
            o_be    = {4'b0, bus32.proc2Dmem_be};
            o_res   = {32'b0, bus32.mem_result_out};
            o_stall = bus32.mem_stall;
            o_rv    = bus32.mem_result_valid;
            o_mis   = bus32.mem_misaligned;
            o_to    = bus32.mem_timeout;
        end else begin
            o_cmd   = bus64.proc2Dmem_command;
            o_addr  = bus64.proc2Dmem_addr;
            o_data  = bus64.proc2Dmem_data;
            o_be    = bus64.proc2Dmem_be;
            o_res   = bus64.mem_result_out;
            o_stall = bus64.mem_stall;
            o_rv    = bus64.mem_result_valid;
            o_mis   = bus64.mem_misaligned;
            o_to    = bus64.mem_timeout;
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t sel=%0d)", tag, obs, exp, $time, sel);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int xl();
        return (sel == 0) ? 32 : 64;
    endfunction

    function automatic int tmo();
        return (sel == 0) ? 4 : 6;
    endfunction

    function automatic logic [63:0] xmask(input int x);
        return (x == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    endfunction

    function automatic logic [63:0] lowmask(input int bits);
        return (bits >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << bits) - 64'd1);
    endfunction

    function automatic int nbytes(input logic [1:0] s);
        return 1 << s;
    endfunction

    function automatic int offset(input logic [63:0] a, input int x);
        return int'(a % 64'(x / 8));
    endfunction

    function automatic bit legal(input logic [63:0] a, input logic [1:0] s, input int x);
        if (s == 2'b11 && x == 32) return 1'b0;
        return (a % 64'(nbytes(s))) == 64'd0;
    endfunction

    function automatic logic [63:0] st_model(input logic [63:0] b, input logic [1:0] s, input int x);
        logic [63:0] v;
        int n;
        v = 64'd0;
        n = nbytes(s) * 8;
        for (int i = 0; i < x; i += n) v |= (b & lowmask(n)) << i;
        return v & xmask(x);
    endfunction

    function automatic logic [63:0] be_model(input logic [63:0] a, input logic [1:0] s, input int x);
        logic [63:0] m;
        m = lowmask(nbytes(s)) << offset(a, x);
        return m & 64'hFF;
    endfunction

    function automatic logic [63:0] ld_model(input logic [63:0] d, input logic [63:0] a,
                                             input logic [1:0] s, input logic u, input int x);
        logic [63:0] v;
        int n;
        n = nbytes(s) * 8;
        v = ((d & xmask(x)) >> (offset(a, x) * 8)) & lowmask(n);
        if (!u && v[n-1]) v |= ~lowmask(n);
        return v & xmask(x);
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_inputs();
        valid = 0; rd = 0; wr = 0; size = 0; uns = 0;
        alu = 0; regb = 0; ddata = 0; ready = 0; dvalid = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_cmd"}, o_cmd, C_NONE);
        check({tag, "_addr"}, o_addr, 0);
        check({tag, "_data"}, o_data, 0);
        check({tag, "_be"}, o_be, 0);
        check({tag, "_stall"}, o_stall, 0);
        check({tag, "_res"}, o_res, 0);
        check({tag, "_rv"}, o_rv, 0);
        check({tag, "_mis"}, o_mis, 0);
        check({tag, "_to"}, o_to, 0);
    endtask

    // One idle/non-memory cycle; a stale response is offered and must be ignored.
    task automatic run_idle(input bit nonmem, input logic [63:0] a, input bit stale);
        quiet_inputs();
        valid  = nonmem;
        alu    = a;
        dvalid = stale;
        ddata  = {$urandom, $urandom};
        @(negedge clk);
        check("idle_cmd", o_cmd, C_NONE);
        check("idle_stall", o_stall, 0);
        check("idle_rv", o_rv, nonmem);
        check("idle_mis", o_mis, 0);
        check("idle_to", o_to, 0);
        if (nonmem) check("idle_res", o_res, a & xmask(xl()));
        adv();
    endtask

    // One memory instruction: ready arrives after rdly stalled cycles;
    // load data arrives on wait cycle vdly (0 = never, forcing a timeout).
    task automatic run_mem(input bit ld, input logic [1:0] s, input logic u,
                           input logic [63:0] a, input logic [63:0] b,
                           input logic [63:0] d, input int rdly, input int vdly);
        int x, t;
        x = xl();
        t = tmo();
        quiet_inputs();
        valid = 1; rd = ld; wr = !ld; size = s; uns = u; alu = a; regb = b; ddata = d;
        if (!legal(a, s, x)) begin
            ready  = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("mis_cmd", o_cmd, C_NONE);
            check("mis_flag", o_mis, 1);
            check("mis_rv", o_rv, 1);
            check("mis_res", o_res, 0);
            check("mis_stall", o_stall, 0);
            adv();
            return;
        end
        for (int c = 0; c <= rdly; c++) begin
            ready  = (c == rdly);
            dvalid = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("iss_cmd", o_cmd, ld ? C_LOAD : C_STORE);
            check("iss_addr", o_addr, a & ~64'(x / 8 - 1) & xmask(x));
            check("iss_be", o_be, be_model(a, s, x));
            if (!ld) check("iss_sdata", o_data, st_model(b, s, x));
            check("iss_stall", o_stall, (c < rdly) || ld);
            check("iss_rv", o_rv, !ld && (c == rdly));
            if (!ld && c == rdly) check("st_res", o_res, a & xmask(x));
            check("iss_mis", o_mis, 0);
            adv();
        end
        if (ld) begin
            for (int k = 1; k <= t; k++) begin
                ready  = 1'($urandom_range(0, 1));
                dvalid = (k == vdly);
                @(negedge clk);
                check("wt_cmd", o_cmd, C_NONE);
                check("wt_be", o_be, 0);
                if (k == vdly) begin
                    check("ld_stall", o_stall, 0);
                    check("ld_rv", o_rv, 1);
                    check("ld_res", o_res, ld_model(d, a, s, u, x));
                    check("ld_to", o_to, 0);
                    adv();
                    break;
                end else if (k == t) begin
                    check("to_flag", o_to, 1);
                    check("to_stall", o_stall, 0);
                    check("to_rv", o_rv, 1);
                    check("to_res", o_res, 0);
                    adv();
                    break;
                end else begin
                    check("wt_stall", o_stall, 1);
                    check("wt_rv", o_rv, 0);
                    check("wt_to", o_to, 0);
                end
                adv();
            end
        end
        quiet_inputs();
    endtask

    initial begin
        sel = 0;
        quiet_inputs();
        rst = 1;
        adv();
        @(negedge clk);
        check_all_zero("rst");
        adv();
        rst = 0;

        // Directed cases on the 32-bit instance.
        run_mem(0, 2'b10, 0, 64'h1004, 64'hDEADBEEF, 0, 0, 0);
        run_mem(0, 2'b00, 0, 64'h1003, 64'h000000A5, 0, 3, 0);
        run_mem(1, 2'b00, 0, 64'h2001, 0, 64'h0000_80FF, 0, 2);
        run_mem(1, 2'b00, 1, 64'h2001, 0, 64'h0000_80FF, 0, 2);
        run_mem(1, 2'b01, 0, 64'h2001, 0, 0, 0, 1);
        run_mem(1, 2'b11, 0, 64'h2000, 0, 0, 0, 1);
        run_mem(1, 2'b10, 0, 64'h3000, 0, 0, 0, 0);
        run_idle(0, 0, 1);
        run_idle(1, 64'h1234_5678, 1);

        // Reset while a load is outstanding; the next-cycle response is dropped.
        quiet_inputs();
        valid = 1; rd = 1; size = 2'b10; alu = 64'h4000; ready = 1;
        adv();
        ready = 0;
        rst = 1;
        @(negedge clk);
        check_all_zero("rstw");
        adv();
        rst = 0;
        run_idle(0, 0, 1);

        // Directed cases on the 64-bit instance.
        sel = 1;
        run_mem(1, 2'b11, 0, 64'h8, 0, 64'h0123_4567_89AB_CDEF, 0, 1);
        run_mem(0, 2'b01, 0, 64'h1006, 64'h0000_BEEF, 0, 1, 0);
        run_mem(1, 2'b10, 0, 64'h0C, 0, 64'h8000_0001_0000_0000, 0, 3);

        // Random transactions on both instances.
        for (int n = 0; n < 300; n++) begin
            logic [63:0] a;
            int kind;
            sel  = $urandom_range(0, 1);
            kind = $urandom_range(0, 9);
            a    = {$urandom, $urandom};
            size = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0) a = a & ~64'(nbytes(size) - 1);
            if (kind < 4)
                run_mem(1, size, 1'($urandom_range(0, 1)), a, 0, {$urandom, $urandom},
                        $urandom_range(0, 3), $urandom_range(0, tmo()));
            else if (kind < 8)
                run_mem(0, size, 0, a, {$urandom, $urandom}, 0, $urandom_range(0, 3), 0);
            else
                run_idle(kind == 8, a, 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
